// File: rtl/dsp_voice_scheduler.sv
// Per-sample voice scheduler: runs N voice engines in turn, muxes the shared mult/div operands and emits a saturated mix.
// Optional per-voice timeout enabled by defining DSP_VOICE_SCHEDULER_TIMEOUT_EN.
module dsp_voice_scheduler #(
  parameter int unsigned N_VOICES       = 4,
  parameter int unsigned GAIN_SHIFT     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_tick,
  output logic                     busy,
  output logic                     sample_valid,
  output logic signed [23:0]       sample_out,
  output logic                     overrun,
  output logic                     timeout_err,
  output logic [N_VOICES-1:0]      voice_start,
  input  logic [N_VOICES-1:0]      voice_finish,
  input  logic [24*N_VOICES-1:0]   voice_wave,
  input  logic [32*N_VOICES-1:0]   voice_mult_a,
  input  logic [32*N_VOICES-1:0]   voice_mult_b,
  input  logic [48*N_VOICES-1:0]   voice_div_n,
  input  logic [48*N_VOICES-1:0]   voice_div_d,
  output logic [31:0]              mult_a,
  output logic [31:0]              mult_b,
  output logic [47:0]              div_n,
  output logic [47:0]              div_d
);

  localparam int unsigned IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int unsigned ACC_W = 24 + $clog2(N_VOICES) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(8388607);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(8388608));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_OUT} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic signed [23:0]      wave_sel;
  logic signed [23:0]      sat;
  logic                    last_voice;

  assign wave_sel   = voice_wave[24*int'(idx) +: 24];
  assign last_voice = (idx == IDX_W'(N_VOICES - 1));
  assign shifted    = acc >>> GAIN_SHIFT;
  assign sat        = (shifted > SAT_MAX) ? 24'sh7FFFFF :
                      (shifted < SAT_MIN) ? 24'sh800000 : shifted[23:0];

  // Shared-unit operands follow the selected voice only while it runs
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    div_n  = '0;
    div_d  = '0;
    if (state == S_RUN) begin
      mult_a = voice_mult_a[32*int'(idx) +: 32];
      mult_b = voice_mult_b[32*int'(idx) +: 32];
      div_n  = voice_div_n[48*int'(idx) +: 48];
      div_d  = voice_div_d[48*int'(idx) +: 48];
    end
  end

`ifdef DSP_VOICE_SCHEDULER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TO_W-1:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
      voice_start  <= '0;
`ifdef DSP_VOICE_SCHEDULER_TIMEOUT_EN
      timeout_err  <= 1'b0;
      to_cnt       <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && (state != S_IDLE))
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            acc         <= '0;
            idx         <= '0;
            state       <= S_RUN;
            busy        <= 1'b1;
            voice_start <= N_VOICES'(1);
`ifdef DSP_VOICE_SCHEDULER_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end
        end
        S_RUN: begin
          if (voice_finish[idx]) begin
            acc         <= acc + ACC_W'(wave_sel);
            state       <= S_GAP;
            voice_start <= '0;
          end
`ifdef DSP_VOICE_SCHEDULER_TIMEOUT_EN
          // A hung voice contributes nothing once its RUN budget is spent
          else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_GAP;
            voice_start <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (last_voice) begin
            state <= S_OUT;
          end else begin
            idx         <= idx + 1'b1;
            state       <= S_RUN;
            voice_start <= N_VOICES'(1) << (idx + 1'b1);
`ifdef DSP_VOICE_SCHEDULER_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end
        end
        S_OUT: begin
          sample_out   <= sat;
          sample_valid <= 1'b1;
          state        <= S_IDLE;
          busy         <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
